// File: rtl/bellek_hakem_pkg.sv
// Shared definitions for the iomem arbiter.
//   hakem_durum_t   : arbiter FSM states (BOSTA idle, ISTEK bus request, YANIT response)
//   hakem_id_t      : grant identifiers (GO = instruction side, YO = data side)
//   HAKEM_HATA_VERI : read data returned on a timed-out transaction
package bellek_hakem_pkg;

  typedef enum logic [1:0] {
    HAKEM_BOSTA = 2'd0,
    HAKEM_ISTEK = 2'd1,
    HAKEM_YANIT = 2'd2
  } hakem_durum_t;

  typedef enum logic {
    HAKEM_GO = 1'b0,
    HAKEM_YO = 1'b1
  } hakem_id_t;

  localparam logic [31:0] HAKEM_HATA_VERI = 32'h0;

endpackage

// File: rtl/bellek_hakem.sv
// Two-requester round-robin arbiter in front of the single iomem port.
//   clk_i, rst_i        : clock (rising edge), synchronous active-high reset
//   go_istek_i/adres_i  : instruction-cache miss read request
//   go_veri_o/hazir_o/hata_o : read data, one-cycle completion pulse, timeout flag
//   yo_istek_i/adres_i/yaz_veri_i/wstrb_i : data-cache miss request (wstrb=0 is a read)
//   yo_veri_o/hazir_o/hata_o : same meaning as the go outputs
//   iomem_*             : registered bus request, ready/rdata back from memory
// A transaction that sees no iomem_ready for ZAMAN_ASIMI cycles is ended with
// hata=1 and zero data; ZAMAN_ASIMI=0 disables the timeout.
module bellek_hakem #(
  parameter int unsigned ZAMAN_ASIMI = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        go_istek_i,
  input  logic [31:0] go_adres_i,
  output logic [31:0] go_veri_o,
  output logic        go_hazir_o,
  output logic        go_hata_o,
  input  logic        yo_istek_i,
  input  logic [31:0] yo_adres_i,
  input  logic [31:0] yo_yaz_veri_i,
  input  logic [3:0]  yo_wstrb_i,
  output logic [31:0] yo_veri_o,
  output logic        yo_hazir_o,
  output logic        yo_hata_o,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata
);
  import bellek_hakem_pkg::*;

  localparam int unsigned SAYAC_W = (ZAMAN_ASIMI == 0) ? 1 : $clog2(ZAMAN_ASIMI + 1);
  localparam logic [SAYAC_W-1:0] SAYAC_SON = SAYAC_W'(ZAMAN_ASIMI);

  hakem_durum_t       durum, durum_d;
  hakem_id_t          sahip, sahip_d;   // current grant
  hakem_id_t          son, son_d;       // last-served requester
  hakem_id_t          kazanan;
  logic [SAYAC_W-1:0] sayac, sayac_d, sayac_art;
  logic               zaman_doldu;

  logic        valid_d;
  logic [3:0]  wstrb_d;
  logic [31:0] addr_d, wdata_d;
  logic [31:0] go_veri_d, yo_veri_d;
  logic        go_hazir_d, go_hata_d, yo_hazir_d, yo_hata_d;

  // Tie goes to whoever was not served last.
  always_comb begin
    if (go_istek_i && yo_istek_i) begin
      kazanan = (son == HAKEM_GO) ? HAKEM_YO : HAKEM_GO;
    end else if (yo_istek_i) begin
      kazanan = HAKEM_YO;
    end else begin
      kazanan = HAKEM_GO;
    end
  end

  // Saturating so a disabled timeout can never wrap back to a match.
  assign sayac_art   = (sayac == '1) ? sayac : sayac + SAYAC_W'(1);
  assign zaman_doldu = (ZAMAN_ASIMI != 0) && (sayac_art == SAYAC_SON);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case leaves one unassigned, which would infer a latch.
    durum_d    = durum;
    sahip_d    = sahip;
    son_d      = son;
    sayac_d    = sayac;
    valid_d    = iomem_valid;
    addr_d     = iomem_addr;
    wdata_d    = iomem_wdata;
    wstrb_d    = iomem_wstrb;
    go_veri_d  = go_veri_o;
    go_hata_d  = go_hata_o;
    yo_veri_d  = yo_veri_o;
    yo_hata_d  = yo_hata_o;
    go_hazir_d = 1'b0;
    yo_hazir_d = 1'b0;

    case (durum)
      HAKEM_BOSTA: begin
        if (go_istek_i || yo_istek_i) begin
          sahip_d = kazanan;
          sayac_d = '0;
          valid_d = 1'b1;
          durum_d = HAKEM_ISTEK;
          if (kazanan == HAKEM_YO) begin
            addr_d  = yo_adres_i;
            wdata_d = yo_yaz_veri_i;
            wstrb_d = yo_wstrb_i;
          end else begin
            addr_d  = go_adres_i;
            wdata_d = '0;
            wstrb_d = '0;
          end
        end
      end

      HAKEM_ISTEK: begin
        if (iomem_ready || zaman_doldu) begin
          // A ready arriving on the timeout cycle still counts as success.
          valid_d = 1'b0;
          son_d   = sahip;
          durum_d = HAKEM_YANIT;
          if (sahip == HAKEM_GO) begin
            go_veri_d  = iomem_ready ? iomem_rdata : HAKEM_HATA_VERI;
            go_hata_d  = !iomem_ready;
            go_hazir_d = 1'b1;
          end else begin
            yo_veri_d  = iomem_ready ? iomem_rdata : HAKEM_HATA_VERI;
            yo_hata_d  = !iomem_ready;
            yo_hazir_d = 1'b1;
          end
        end else begin
          sayac_d = sayac_art;
        end
      end

      // Requests are deliberately not looked at here; a held istek is
      // picked up from BOSTA on the following edge.
      HAKEM_YANIT: durum_d = HAKEM_BOSTA;

      default: durum_d = HAKEM_BOSTA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum       <= HAKEM_BOSTA;
      sahip       <= HAKEM_GO;
      son         <= HAKEM_YO;
      sayac       <= '0;
      iomem_valid <= 1'b0;
      iomem_addr  <= '0;
      iomem_wdata <= '0;
      iomem_wstrb <= '0;
      go_veri_o   <= '0;
      go_hazir_o  <= 1'b0;
      go_hata_o   <= 1'b0;
      yo_veri_o   <= '0;
      yo_hazir_o  <= 1'b0;
      yo_hata_o   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      durum       <= durum_d;
      sahip       <= sahip_d;
      son         <= son_d;
      sayac       <= sayac_d;
      iomem_valid <= valid_d;
      iomem_addr  <= addr_d;
      iomem_wdata <= wdata_d;
      iomem_wstrb <= wstrb_d;
      go_veri_o   <= go_veri_d;
      go_hazir_o  <= go_hazir_d;
      go_hata_o   <= go_hata_d;
      yo_veri_o   <= yo_veri_d;
      yo_hazir_o  <= yo_hazir_d;
      yo_hata_o   <= yo_hata_d;
    end
  end

endmodule

// File: tb/tb_bellek_hakem.sv
// Bench for bellek_hakem: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_bellek_hakem;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go_istek = 1'b0, yo_istek = 1'b0;
  logic [31:0] go_adres = '0, yo_adres = '0, yo_yaz_veri = '0;
  logic [3:0]  yo_wstrb = '0;
  logic        iomem_ready = 1'b0;
  logic [31:0] iomem_rdata = '0;
  logic [31:0] go_veri, yo_veri, iomem_addr, iomem_wdata;
  logic        go_hazir, go_hata, yo_hazir, yo_hata, iomem_valid;
  logic [3:0]  iomem_wstrb;

  bellek_hakem #(.ZAMAN_ASIMI(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .go_istek_i(go_istek), .go_adres_i(go_adres),
    .go_veri_o(go_veri), .go_hazir_o(go_hazir), .go_hata_o(go_hata),
    .yo_istek_i(yo_istek), .yo_adres_i(yo_adres), .yo_yaz_veri_i(yo_yaz_veri),
    .yo_wstrb_i(yo_wstrb),
    .yo_veri_o(yo_veri), .yo_hazir_o(yo_hazir), .yo_hata_o(yo_hata),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one bus transaction at a time) -------
  // Expected visible outputs for the current cycle.
  logic        e_valid, e_go_hazir, e_yo_hazir, e_go_hata, e_yo_hata;
  logic [31:0] e_addr, e_wdata, e_go_veri, e_yo_veri;
  logic [3:0]  e_wstrb;
  logic        owner_yo, last_yo;
  int          bus_age;
  logic        chk_en = 1'b0;

  task automatic deliver(input logic [31:0] v, input logic h);
    e_valid = 1'b0;
    if (owner_yo) begin e_yo_veri = v; e_yo_hata = h; e_yo_hazir = 1'b1; end
    else          begin e_go_veri = v; e_go_hata = h; e_go_hazir = 1'b1; end
    last_yo = owner_yo;
  endtask

  // Predict what the outputs will be after the next edge, given the inputs now.
  task automatic model_update();
    if (rst) begin
      e_valid = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0;
      e_go_hazir = 0; e_yo_hazir = 0; e_go_hata = 0; e_yo_hata = 0;
      e_go_veri = 0; e_yo_veri = 0; last_yo = 1'b1; bus_age = 0;
    end else if (e_go_hazir || e_yo_hazir) begin
      e_go_hazir = 0;                       // response cycle: requests ignored
      e_yo_hazir = 0;
    end else if (e_valid) begin
      bus_age++;
      if (iomem_ready)        deliver(iomem_rdata, 1'b0);
      else if (bus_age == TMO) deliver(32'h0, 1'b1);
    end else if (go_istek || yo_istek) begin
      owner_yo = (go_istek && yo_istek) ? !last_yo : yo_istek;
      bus_age  = 0;
      e_valid  = 1'b1;
      e_addr   = owner_yo ? yo_adres    : go_adres;
      e_wdata  = owner_yo ? yo_yaz_veri : 32'h0;
      e_wstrb  = owner_yo ? yo_wstrb    : 4'h0;
    end
  endtask

  // Single compare process, sampling 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("mdl_valid", {31'b0, iomem_valid}, {31'b0, e_valid});
      check("mdl_go_hazir", {31'b0, go_hazir}, {31'b0, e_go_hazir});
      check("mdl_yo_hazir", {31'b0, yo_hazir}, {31'b0, e_yo_hazir});
      if (e_valid) begin
        check("mdl_addr", iomem_addr, e_addr);
        check("mdl_wdata", iomem_wdata, e_wdata);
        check("mdl_wstrb", {28'b0, iomem_wstrb}, {28'b0, e_wstrb});
      end
      if (e_go_hazir) begin
        check("mdl_go_veri", go_veri, e_go_veri);
        check("mdl_go_hata", {31'b0, go_hata}, {31'b0, e_go_hata});
      end
      if (e_yo_hazir) begin
        check("mdl_yo_veri", yo_veri, e_yo_veri);
        check("mdl_yo_hata", {31'b0, yo_hata}, {31'b0, e_yo_hata});
      end
    end
  end

  // Inputs are set by the caller before tick; they are sampled at the next edge.
  task automatic tick();
    model_update();
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  logic ord [4];
  int   n_ord;
  int   n_valid;
  logic go_pend, yo_pend;

  initial begin
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Reset values.
    check("rst_valid", {31'b0, iomem_valid}, 32'd0);
    check("rst_addr", iomem_addr, 32'd0);
    check("rst_wdata", iomem_wdata, 32'd0);
    check("rst_wstrb", {28'b0, iomem_wstrb}, 32'd0);
    check("rst_hazir", {30'b0, go_hazir, yo_hazir}, 32'd0);
    check("rst_hata", {30'b0, go_hata, yo_hata}, 32'd0);
    check("rst_go_veri", go_veri, 32'd0);
    check("rst_yo_veri", yo_veri, 32'd0);

    // go read, ready in first bus cycle.
    go_istek = 1'b1; go_adres = 32'h0000_0100;
    tick();
    check("go_rd_valid", {31'b0, iomem_valid}, 32'd1);
    check("go_rd_addr", iomem_addr, 32'h0000_0100);
    check("go_rd_wstrb", {28'b0, iomem_wstrb}, 32'd0);
    iomem_ready = 1'b1; iomem_rdata = 32'h1234_5678;
    tick();
    check("go_rd_hazir", {31'b0, go_hazir}, 32'd1);
    check("go_rd_veri", go_veri, 32'h1234_5678);
    check("go_rd_valid_off", {31'b0, iomem_valid}, 32'd0);
    go_istek = 1'b0; iomem_ready = 1'b0;
    tick();

    // yo write, ready in 5th bus cycle.
    yo_istek = 1'b1; yo_adres = 32'h2000_0004; yo_yaz_veri = 32'hCAFE_BABE; yo_wstrb = 4'b0011;
    tick();
    for (int i = 1; i <= 5; i++) begin
      check("yo_wr_valid", {31'b0, iomem_valid}, 32'd1);
      check("yo_wr_addr", iomem_addr, 32'h2000_0004);
      check("yo_wr_wdata", iomem_wdata, 32'hCAFE_BABE);
      check("yo_wr_wstrb", {28'b0, iomem_wstrb}, 32'd3);
      iomem_ready = (i == 5);
      tick();
    end
    check("yo_wr_hazir", {31'b0, yo_hazir}, 32'd1);
    check("yo_wr_hata", {31'b0, yo_hata}, 32'd0);
    yo_istek = 1'b0; iomem_ready = 1'b0;
    tick();
    check("yo_wr_hazir_once", {31'b0, yo_hazir}, 32'd0);

    // Both requesting from reset: go, yo, go, yo.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    go_istek = 1'b1; yo_istek = 1'b1; yo_wstrb = 4'h0; iomem_ready = 1'b1;
    n_ord = 0;
    for (int i = 0; i < 40 && n_ord < 4; i++) begin
      tick();
      check("rr_one_hazir", {31'b0, go_hazir & yo_hazir}, 32'd0);
      if (go_hazir && n_ord < 4) begin ord[n_ord] = 1'b0; n_ord++; end
      else if (yo_hazir && n_ord < 4) begin ord[n_ord] = 1'b1; n_ord++; end
    end
    check("rr_count", n_ord, 32'd4);
    check("rr_order", {28'b0, ord[0], ord[1], ord[2], ord[3]}, 32'b0101);
    go_istek = 1'b0; yo_istek = 1'b0; iomem_ready = 1'b0;
    tick();

    // Timeout with ready stuck low.
    go_istek = 1'b1; go_adres = 32'h0000_0400;
    tick();
    n_valid = 0;
    for (int i = 0; i < 20 && iomem_valid; i++) begin
      n_valid++;
      tick();
    end
    check("tmo_valid_cycles", n_valid, TMO);
    check("tmo_hazir", {31'b0, go_hazir}, 32'd1);
    check("tmo_hata", {31'b0, go_hata}, 32'd1);
    check("tmo_veri", go_veri, 32'd0);
    go_istek = 1'b0;
    tick();

    // Reset in the 3rd bus cycle of a yo read.
    yo_istek = 1'b1; yo_adres = 32'h0000_0800; yo_wstrb = 4'h0;
    tick();
    tick();
    tick();
    check("rst_mid_valid_before", {31'b0, iomem_valid}, 32'd1);
    rst = 1'b1; yo_istek = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_mid_valid", {31'b0, iomem_valid}, 32'd0);
    check("rst_mid_hazir", {30'b0, go_hazir, yo_hazir}, 32'd0);
    check("rst_mid_addr", iomem_addr, 32'd0);
    check("rst_mid_veri", yo_veri, 32'd0);
    tick();
    check("rst_mid_no_hazir", {31'b0, yo_hazir}, 32'd0);
    go_istek = 1'b1; go_adres = 32'h0000_0300;
    tick();
    check("post_rst_addr", iomem_addr, 32'h0000_0300);
    iomem_ready = 1'b1; iomem_rdata = 32'hA5A5_0001;
    tick();
    check("post_rst_hazir", {31'b0, go_hazir}, 32'd1);
    check("post_rst_veri", go_veri, 32'hA5A5_0001);
    go_istek = 1'b0; iomem_ready = 1'b0;
    tick();

    // Stray ready while idle.
    iomem_ready = 1'b1;
    tick();
    iomem_ready = 1'b0;
    tick();
    check("idle_ready_valid", {31'b0, iomem_valid}, 32'd0);
    check("idle_ready_hazir", {30'b0, go_hazir, yo_hazir}, 32'd0);

    // Randomized traffic under the requester contract.
    go_pend = 1'b0; yo_pend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (e_go_hazir) go_pend = 1'b0;
      if (e_yo_hazir) yo_pend = 1'b0;
      if (!go_pend) begin
        go_istek = ($urandom_range(0, 1) == 1);
        go_adres = $urandom;
        go_pend  = go_istek;
      end
      if (!yo_pend) begin
        yo_istek    = ($urandom_range(0, 1) == 1);
        yo_adres    = $urandom;
        yo_yaz_veri = $urandom;
        yo_wstrb    = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
        yo_pend     = yo_istek;
      end
      iomem_ready = e_valid ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) == 0);
      iomem_rdata = $urandom;
      rst = ($urandom_range(0, 399) == 0);
      if (rst) begin
        go_istek = 1'b0; yo_istek = 1'b0; go_pend = 1'b0; yo_pend = 1'b0;
      end
      tick();
    end
    rst = 1'b0; go_istek = 1'b0; yo_istek = 1'b0; iomem_ready = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
